// File: rtl/rom_ctrl_pkg.sv
// Shared types and default widths for the ROM check KMAC feeder.
package rom_ctrl_pkg;

  localparam int DefDataWidth     = 39;
  localparam int DefKmacDataWidth = 64;
  localparam int DefDigestWidth   = 256;

  // Each pair of encodings differs in at least four bits, so a single upset cannot produce another valid state.
  typedef enum logic [7:0] {
    StFeed       = 8'h0F,
    StWaitDigest = 8'h33,
    StDone       = 8'hCC,
    StError      = 8'hF0
  } feeder_state_e;

endpackage

// File: rtl/rom_ctrl_kmac_feeder_if.sv
// Bundle of the ROM-word input, KMAC application and status signals of the feeder.
interface rom_ctrl_kmac_feeder_if #(
  parameter int DataWidth     = rom_ctrl_pkg::DefDataWidth,
  parameter int KmacDataWidth = rom_ctrl_pkg::DefKmacDataWidth,
  parameter int DigestWidth   = rom_ctrl_pkg::DefDigestWidth
);
  logic                     data_vld_i;
  logic [DataWidth-1:0]     data_i;
  logic                     data_last_nontop_i;
  logic                     data_rdy_o;
  logic                     kmac_req_o;
  logic [KmacDataWidth-1:0] kmac_data_o;
  logic                     kmac_last_o;
  logic                     kmac_ack_i;
  logic                     kmac_done_i;
  logic [DigestWidth-1:0]   kmac_digest_i;
  logic [DigestWidth-1:0]   digest_o;
  logic                     done_o;
  logic                     err_o;

  modport master (
    output data_vld_i, data_i, data_last_nontop_i, kmac_ack_i, kmac_done_i, kmac_digest_i,
    input  data_rdy_o, kmac_req_o, kmac_data_o, kmac_last_o, digest_o, done_o, err_o
  );

  modport slave (
    input  data_vld_i, data_i, data_last_nontop_i, kmac_ack_i, kmac_done_i, kmac_digest_i,
    output data_rdy_o, kmac_req_o, kmac_data_o, kmac_last_o, digest_o, done_o, err_o
  );
endinterface

// File: rtl/rom_ctrl_feeder_stage.sv
// One-entry register slice; a load in the same cycle as a drain replaces the word and keeps it full.
module rom_ctrl_feeder_stage #(
  parameter int Width = rom_ctrl_pkg::DefDataWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [Width-1:0] load_data,
  input  logic             load_last,
  output logic             full,
  output logic [Width-1:0] data,
  output logic             last
);

  logic             full_reg;
  logic [Width-1:0] data_reg;
  logic             last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
      last_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
      data_reg <= load_data;
      last_reg <= load_last;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign data = data_reg;
  assign last = last_reg;

endmodule

// File: rtl/rom_ctrl_kmac_feeder.sv
// Forwards ROM words to KMAC, captures the digest and reports completion.
// Optional protocol checks are enabled by defining ROM_CTRL_KMAC_FEEDER_CHECK_EN.
module rom_ctrl_kmac_feeder
  import rom_ctrl_pkg::*;
#(
  parameter int DataWidth     = DefDataWidth,
  parameter int KmacDataWidth = DefKmacDataWidth,
  parameter int DigestWidth   = DefDigestWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  rom_ctrl_kmac_feeder_if.slave  bus
);

`ifdef ROM_CTRL_KMAC_FEEDER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  feeder_state_e          state_reg;
  logic [DigestWidth-1:0] digest_reg;
  logic                   done_reg;
  logic                   err_reg;

  logic                   in_feed;
  logic                   full;
  logic                   last;
  logic [DataWidth-1:0]   stage_data;
  logic                   data_rdy;
  logic                   kmac_req;
  logic                   load;
  logic                   drain;
  logic [KmacDataWidth-1:0] data_ext;

  assign in_feed = (state_reg == StFeed);
  // Once the last word is held, no further word may enter, even while it drains.
  assign data_rdy = in_feed & (~full | (bus.kmac_ack_i & ~last));
  assign kmac_req = in_feed & full;
  assign load     = bus.data_vld_i & data_rdy;
  assign drain    = kmac_req & bus.kmac_ack_i;

  rom_ctrl_feeder_stage #(
    .Width (DataWidth)
  ) u_stage (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (load),
    .drain     (drain),
    .load_data (bus.data_i),
    .load_last (bus.data_last_nontop_i),
    .full      (full),
    .data      (stage_data),
    .last      (last)
  );

  always_comb begin
    data_ext                = '0;
    data_ext[DataWidth-1:0] = stage_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= StFeed;
      digest_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        StFeed: begin
          if (CheckEn && bus.kmac_done_i) begin
            state_reg <= StError;
            err_reg   <= 1'b1;
          end else if (drain && last) begin
            state_reg <= StWaitDigest;
          end
        end
        StWaitDigest: begin
          if (CheckEn && bus.data_vld_i) begin
            state_reg <= StError;
            err_reg   <= 1'b1;
          end else if (bus.kmac_done_i) begin
            state_reg  <= StDone;
            digest_reg <= bus.kmac_digest_i;
            done_reg   <= 1'b1;
          end
        end
        StDone: begin
          if (CheckEn && bus.kmac_done_i) begin
            state_reg <= StError;
            err_reg   <= 1'b1;
          end
        end
        StError: begin
          state_reg <= StError;
        end
        default: begin
          // An illegal encoding is treated as a fault when checks are on.
          state_reg <= CheckEn ? StError : StFeed;
          err_reg   <= CheckEn;
        end
      endcase
    end
  end

  assign bus.data_rdy_o  = data_rdy;
  assign bus.kmac_req_o  = kmac_req;
  assign bus.kmac_data_o = data_ext;
  assign bus.kmac_last_o = last;
  assign bus.digest_o    = digest_reg;
  assign bus.done_o      = done_reg;
  assign bus.err_o       = CheckEn & err_reg;

endmodule

// File: tb/tb_rom_ctrl_kmac_feeder.sv
// Self-checking bench for rom_ctrl_kmac_feeder against a queue-based transfer model.
module tb_rom_ctrl_kmac_feeder;

  localparam int DW  = 39;
  localparam int KW  = 64;
  localparam int GW  = 256;

`ifdef ROM_CTRL_KMAC_FEEDER_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  localparam int P_FEED = 0;
  localparam int P_WAIT = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  typedef struct packed {
    logic [KW-1:0] data;
    logic          last;
  } word_t;

  logic clk_i;
  logic rst_ni;

  rom_ctrl_kmac_feeder_if #(.DataWidth(DW), .KmacDataWidth(KW), .DigestWidth(GW)) bus ();

  rom_ctrl_kmac_feeder #(.DataWidth(DW), .KmacDataWidth(KW), .DigestWidth(GW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: words accepted but not yet delivered, plus protocol phase.
  word_t         q[$];
  logic [KW-1:0] beat_log[$];
  int            phase;
  bit            last_taken;
  bit            exp_done;
  logic [GW-1:0] exp_digest;
  int            beat_count;
  int            first_beat_cyc;
  int            last_beat_cyc;
  int            cyc;
  bit            accepted;

  int checks;
  int errors;

  task automatic model_reset();
    q.delete();
    beat_log.delete();
    phase          = P_FEED;
    last_taken     = 1'b0;
    exp_done       = 1'b0;
    exp_digest     = '0;
    beat_count     = 0;
    first_beat_cyc = -1;
    last_beat_cyc  = -1;
    cyc            = 0;
  endtask

  task automatic idle_inputs();
    bus.data_vld_i         = 1'b0;
    bus.data_i             = '0;
    bus.data_last_nontop_i = 1'b0;
    bus.kmac_ack_i         = 1'b0;
    bus.kmac_done_i        = 1'b0;
    bus.kmac_digest_i      = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare handshake outputs, advance the model, compare registered outputs.
  task automatic step(input logic vld, input logic [DW-1:0] d, input logic lst,
                      input logic ack, input logic done, input logic [GW-1:0] dig);
    logic  exp_req;
    logic  exp_rdy;
    bit    beat;
    word_t w;
    bus.data_vld_i         = vld;
    bus.data_i             = d;
    bus.data_last_nontop_i = lst;
    bus.kmac_ack_i         = ack;
    bus.kmac_done_i        = done;
    bus.kmac_digest_i      = dig;
    #1;
    exp_req = (phase == P_FEED) && (q.size() != 0);
    exp_rdy = (phase == P_FEED) && !last_taken && ((q.size() == 0) || ack);
    checks++;
    if (bus.kmac_req_o !== exp_req) begin
      errors++;
      $display("FAIL kmac_req cyc=%0d got=%b exp=%b", cyc, bus.kmac_req_o, exp_req);
    end
    checks++;
    if (bus.data_rdy_o !== exp_rdy) begin
      errors++;
      $display("FAIL data_rdy cyc=%0d got=%b exp=%b", cyc, bus.data_rdy_o, exp_rdy);
    end
    beat     = exp_req && ack;
    accepted = vld && exp_rdy;
    if (beat) begin
      checks++;
      if (bus.kmac_data_o !== q[0].data || bus.kmac_last_o !== q[0].last) begin
        errors++;
        $display("FAIL beat cyc=%0d got=%h/%b exp=%h/%b", cyc, bus.kmac_data_o,
                 bus.kmac_last_o, q[0].data, q[0].last);
      end
      $display("beat cyc=%0d data=%h last=%b", cyc, bus.kmac_data_o, bus.kmac_last_o);
      beat_log.push_back(bus.kmac_data_o);
      beat_count++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
    end
    case (phase)
      P_FEED: begin
        if (CHECK && done) begin
          phase = P_ERR;
        end else begin
          if (beat) begin
            w = q.pop_front();
            if (w.last) phase = P_WAIT;
          end
          if (accepted) begin
            w.data = '0;
            w.data[DW-1:0] = d;
            w.last = lst;
            q.push_back(w);
            if (lst) last_taken = 1'b1;
          end
        end
      end
      P_WAIT: begin
        if (CHECK && vld) begin
          phase = P_ERR;
        end else if (done) begin
          phase      = P_DONE;
          exp_done   = 1'b1;
          exp_digest = dig;
        end
      end
      P_DONE: begin
        if (CHECK && done) phase = P_ERR;
      end
      default: ;
    endcase
    @(posedge clk_i);
    #1;
    checks++;
    if (bus.done_o !== exp_done || bus.digest_o !== exp_digest) begin
      errors++;
      $display("FAIL done_digest cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.done_o,
               bus.digest_o, exp_done, exp_digest);
    end
    checks++;
    if (bus.err_o !== (phase == P_ERR)) begin
      errors++;
      $display("FAIL err cyc=%0d got=%b exp=%b", cyc, bus.err_o, (phase == P_ERR));
    end
    cyc++;
  endtask

  task automatic stream_words(input int n);
    for (int i = 1; i <= n; i++) step(1'b1, DW'(i), (i == n), 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.data_rdy_o !== 1'b1 || bus.kmac_req_o !== 1'b0 || bus.kmac_data_o !== '0 ||
        bus.kmac_last_o !== 1'b0 || bus.digest_o !== '0 || bus.done_o !== 1'b0 ||
        bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b req=%b data=%h last=%b done=%b err=%b exp 1 0 0 0 0 0",
               bus.data_rdy_o, bus.kmac_req_o, bus.kmac_data_o, bus.kmac_last_o,
               bus.done_o, bus.err_o);
    end
  endtask

  task automatic test_streaming();
    apply_reset();
    stream_words(14);
    checks++;
    if (beat_count != 14 || (last_beat_cyc - first_beat_cyc) != 13) begin
      errors++;
      $display("FAIL streaming beats=%0d span=%0d exp 14/13", beat_count,
               last_beat_cyc - first_beat_cyc);
    end
    // In WaitDigest nothing is requested or accepted.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus.data_rdy_o !== 1'b0 || bus.kmac_req_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_digest rdy=%b req=%b exp 0/0", bus.data_rdy_o, bus.kmac_req_o);
    end
  endtask

  task automatic test_digest();
    logic [GW-1:0] a5;
    logic [GW-1:0] other;
    a5    = {32{8'hA5}};
    other = {32{8'h5A}};
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, a5);
    checks++;
    if (bus.done_o !== 1'b1 || bus.digest_o !== a5) begin
      errors++;
      $display("FAIL digest_capture got=%b/%h exp=1/%h", bus.done_o, bus.digest_o, a5);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, other);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (bus.digest_o !== a5 || bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL digest_hold got=%b/%h exp=1/%h", bus.done_o, bus.digest_o, a5);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step(1'b1, DW'(39'h11), 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(39'h22), 1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (bus.kmac_data_o !== KW'(64'h11) || bus.data_rdy_o !== 1'b0) begin
        errors++;
        $display("FAIL backpressure i=%0d data=%h rdy=%b exp 11/0", i, bus.kmac_data_o,
                 bus.data_rdy_o);
      end
    end
    step(1'b1, DW'(39'h22), 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (beat_count != 2 || beat_log[0] !== KW'(64'h11) || beat_log[1] !== KW'(64'h22)) begin
      errors++;
      $display("FAIL backpressure_order beats=%0d exp 2 (11,22)", beat_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[4];
    apply_reset();
    for (int i = 0; i < 4; i++) w[i] = DW'({$urandom(), $urandom()});
    step(1'b1, w[0], 1'b0, 1'b1, 1'b0, '0);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, w[i], 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (bus.kmac_req_o !== 1'b1 || accepted !== 1'b1) begin
        errors++;
        $display("FAIL load_and_ack i=%0d req=%b acc=%b exp 1/1", i, bus.kmac_req_o, accepted);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (beat_count != 4) begin
      errors++;
      $display("FAIL load_and_ack_count got=%0d exp=4", beat_count);
    end
    for (int i = 0; i < 4 && i < beat_count; i++) begin
      checks++;
      if (beat_log[i] !== {{(KW-DW){1'b0}}, w[i]}) begin
        errors++;
        $display("FAIL load_and_ack_word i=%0d got=%h exp=%h", i, beat_log[i], w[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    int            n;
    int            sent;
    logic [DW-1:0] cur;
    int            budget;
    apply_reset();
    n      = $urandom_range(10, 30);
    sent   = 0;
    cur    = DW'({$urandom(), $urandom()});
    budget = 0;
    while ((sent < n || phase == P_FEED) && budget < 400) begin
      if (sent < n) begin
        step(1'b1 & ($urandom_range(0, 3) != 0), cur, (sent == n - 1),
             ($urandom_range(0, 2) != 0), 1'b0, '0);
        if (accepted) begin
          sent++;
          cur = DW'({$urandom(), $urandom()});
        end
      end else begin
        step(1'b0, '0, 1'b0, ($urandom_range(0, 1) != 0), 1'b0, '0);
      end
      budget++;
    end
    checks++;
    if (budget >= 400 || beat_count != n) begin
      errors++;
      $display("FAIL random_stream beats=%0d exp=%0d budget=%0d", beat_count, n, budget);
    end
    $display("random stream of %0d words delivered in %0d cycles", n, budget);
    test_digest();
  endtask

  task automatic test_early_done();
    apply_reset();
    step(1'b1, DW'(39'h5), 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, {8{32'hDEADBEEF}});
    #1;
    checks++;
    if (bus.err_o !== CHECK || bus.kmac_req_o !== !CHECK) begin
      errors++;
      $display("FAIL early_done err=%b req=%b exp=%b/%b", bus.err_o, bus.kmac_req_o,
               CHECK, !CHECK);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0, 1'b1, 1'b0, '0);
    bus.data_vld_i = 1'b1;
    bus.kmac_ack_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.data_rdy_o !== 1'b1 || bus.kmac_req_o !== 1'b0 || bus.kmac_data_o !== '0 ||
        bus.kmac_last_o !== 1'b0 || bus.digest_o !== '0 || bus.done_o !== 1'b0 ||
        bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset rdy=%b req=%b data=%h last=%b done=%b err=%b exp 1 0 0 0 0 0",
               bus.data_rdy_o, bus.kmac_req_o, bus.kmac_data_o, bus.kmac_last_o,
               bus.done_o, bus.err_o);
    end
    apply_reset();
    stream_words(14);
    checks++;
    if (beat_count != 14) begin
      errors++;
      $display("FAIL rerun_beats got=%0d exp=14", beat_count);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, {4{64'h0123456789ABCDEF}});
    checks++;
    if (bus.done_o !== 1'b1 || bus.digest_o !== {4{64'h0123456789ABCDEF}}) begin
      errors++;
      $display("FAIL rerun_done got=%b/%h", bus.done_o, bus.digest_o);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_streaming();
    test_digest();
    test_backpressure();
    test_back_to_back();
    test_early_done();
    test_reset_midstream();
    for (int r = 0; r < 4; r++) test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
